// File: rtl/deccnt_pkg.sv
// Shared encodings for the decimal counter controller: modes, button
// indices, command priority and the BCD digit limit.
package deccnt_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_EDIT = 2'd2
  } mode_e;

  localparam int NUM_BTN = 5;
  localparam int BTN_R   = 0;
  localparam int BTN_L   = 1;
  localparam int BTN_D   = 2;
  localparam int BTN_U   = 3;
  localparam int BTN_C   = 4;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_C    = 3'd1,
    CMD_U    = 3'd2,
    CMD_D    = 3'd3,
    CMD_L    = 3'd4,
    CMD_R    = 3'd5
  } cmd_e;

  // One command per cycle, C > U > D > L > R; losers are simply dropped.
  function automatic cmd_e arbitrate(input logic [NUM_BTN-1:0] btn);
    if (btn[BTN_C])      return CMD_C;
    else if (btn[BTN_U]) return CMD_U;
    else if (btn[BTN_D]) return CMD_D;
    else if (btn[BTN_L]) return CMD_L;
    else if (btn[BTN_R]) return CMD_R;
    else                 return CMD_NONE;
  endfunction

endpackage

// File: rtl/deccnt_ctrl_bcd4_step.sv
// Combinational 4-digit BCD +/-1 with wrap, and a single-digit mod-10 step
// applied to the one-hot selected digit without carry.
module bcd4_step
  import deccnt_pkg::*;
(
  input  logic [15:0] val_i,
  input  logic        up_i,
  input  logic [3:0]  sel_i,
  output logic [15:0] whole_o,
  output logic [15:0] digit_o
);

  function automatic logic [3:0] digit_inc_dec(input logic [3:0] d, input logic up);
    if (up) return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    else    return (d == 4'd0) ? BCD_MAX : d - 4'd1;
  endfunction

  logic carry;

  // Ripple from digit 0; carry/borrow only propagates past a wrapping digit.
  always_comb begin
    carry   = 1'b1;
    whole_o = val_i;
    for (int k = 0; k < 4; k++) begin
      if (carry) begin
        whole_o[4*k +: 4] = digit_inc_dec(val_i[4*k +: 4], up_i);
        carry = up_i ? (val_i[4*k +: 4] >= BCD_MAX) : (val_i[4*k +: 4] == 4'd0);
      end
    end
  end

  always_comb begin
    digit_o = val_i;
    for (int k = 0; k < 4; k++) begin
      if (sel_i[k]) digit_o[4*k +: 4] = digit_inc_dec(val_i[4*k +: 4], up_i);
    end
  end

endmodule

// File: rtl/deccnt_ctrl.sv
// Push-button command controller for the 4-digit BCD counter: IDLE/RUN/EDIT
// FSM, auto-count tick, edit-digit blink and edit inactivity timeout.
module deccnt_ctrl
  import deccnt_pkg::*;
#(
  parameter int TICK_DIV     = 100_000_000,
  parameter int BLINK_DIV    = 25_000_000,
  parameter int EDIT_TIMEOUT = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BTNU_P,
  input  logic        BTND_P,
  input  logic        BTNL_P,
  input  logic        BTNR_P,
  input  logic        BTNC_P,
  output logic [15:0] VAL,
  output logic [3:0]  CURSOR,
  output logic [3:0]  BLANK,
  output logic [1:0]  MODE,
  output logic        DIR
);

  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam int TO_W    = $clog2(EDIT_TIMEOUT + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(EDIT_TIMEOUT - 1);

  mode_e              mode_q, mode_d;
  logic [15:0]        val_q, val_d;
  logic               dir_q, dir_d;
  logic [3:0]         cursor_q, cursor_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;

  cmd_e        cmd;
  logic        tick;
  logic        step_up;
  logic [15:0] whole_val;
  logic [15:0] digit_val;

  assign cmd  = arbitrate({BTNC_P, BTNU_P, BTND_P, BTNL_P, BTNR_P});
  assign tick = (tick_cnt_q == TICK_LAST);

  // RUN steps in the stored direction; IDLE/EDIT steps follow the button.
  assign step_up = (mode_q == MODE_RUN) ? dir_q : (cmd == CMD_U);

  bcd4_step u_step (
    .val_i   (val_q),
    .up_i    (step_up),
    .sel_i   (cursor_q),
    .whole_o (whole_val),
    .digit_o (digit_val)
  );

  always_comb begin
    mode_d      = mode_q;
    val_d       = val_q;
    dir_d       = dir_q;
    cursor_d    = cursor_q;
    to_cnt_d    = to_cnt_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
    phase_d     = (blink_cnt_q == BLINK_LAST) ? ~phase_q : phase_q;

    case (mode_q)
      MODE_IDLE: begin
        case (cmd)
          CMD_C: begin
            mode_d     = MODE_RUN;
            tick_cnt_d = '0;
          end
          CMD_U, CMD_D: val_d = whole_val;
          CMD_L, CMD_R: begin
            mode_d      = MODE_EDIT;
            cursor_d    = 4'b0001;
            to_cnt_d    = '0;
            blink_cnt_d = '0;
            phase_d     = 1'b0;
          end
          default: ;
        endcase
      end
      MODE_RUN: begin
        if (cmd == CMD_C) begin
          mode_d = MODE_IDLE;
        end else begin
          if (tick) val_d = whole_val;
          if (cmd == CMD_U) dir_d = 1'b1;
          if (cmd == CMD_D) dir_d = 1'b0;
        end
      end
      MODE_EDIT: begin
        case (cmd)
          CMD_C:        mode_d   = MODE_IDLE;
          CMD_L:        cursor_d = {cursor_q[2:0], cursor_q[3]};
          CMD_R:        cursor_d = {cursor_q[0], cursor_q[3:1]};
          CMD_U, CMD_D: val_d    = digit_val;
          default: ;
        endcase
        if (cmd != CMD_NONE) begin
          to_cnt_d = '0;
        end else if (tick) begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_q >= TO_LAST) mode_d = MODE_IDLE;
        end
      end
      default: mode_d = MODE_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mode_q      <= MODE_IDLE;
      val_q       <= 16'h0000;
      dir_q       <= 1'b1;
      cursor_q    <= 4'b0001;
      tick_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      mode_q      <= mode_d;
      val_q       <= val_d;
      dir_q       <= dir_d;
      cursor_q    <= cursor_d;
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign VAL    = val_q;
  assign CURSOR = cursor_q;
  assign MODE   = mode_q;
  assign DIR    = dir_q;
  assign BLANK  = (mode_q == MODE_EDIT && phase_q) ? cursor_q : 4'b0000;

endmodule
